// File: rtl/ptw_arbiter.sv
// ptw_arbiter: shares one page-table walker between the ITLB and DTLB miss
// paths. Holds one miss per TLB, folds identical-VPN misses into a single
// walk, alternates distinct misses round-robin and routes the walker's answer
// back to whoever asked.
module ptw_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [21:0]           satp_ppn_i,
  input  logic                  itlb_req_valid_i,
  output logic                  itlb_req_ready_o,
  input  logic [19:0]           itlb_req_vpn_i,
  output logic                  itlb_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] itlb_rsp_pte_o,
  output logic                  itlb_rsp_error_o,
  input  logic                  dtlb_req_valid_i,
  output logic                  dtlb_req_ready_o,
  input  logic [19:0]           dtlb_req_vpn_i,
  output logic                  dtlb_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] dtlb_rsp_pte_o,
  output logic                  dtlb_rsp_error_o,
  output logic                  ptw_req_valid_o,
  input  logic                  ptw_req_ready_i,
  output logic [ADDR_WIDTH-1:0] ptw_req_addr_o,
  output logic [19:0]           ptw_req_vpn_o,
  input  logic                  ptw_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] ptw_rsp_pte_i,
  input  logic                  ptw_rsp_error_i,
  output logic                  busy_o,
  output logic [31:0]           walk_cnt_o,
  output logic [31:0]           merge_cnt_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic                  pendI_q, pendI_d;
  logic                  pendD_q, pendD_d;
  logic [19:0]           vpnI_q, vpnI_d;
  logic [19:0]           vpnD_q, vpnD_d;
  logic [21:0]           base_q, base_d;
  logic                  merge_q, merge_d;
  logic                  ownerD_q, ownerD_d;
  logic                  lastD_q, lastD_d;
  logic [DATA_WIDTH-1:0] rspPte_q, rspPte_d;
  logic                  rspErr_q, rspErr_d;
  logic [31:0]           walkCnt_q, walkCnt_d;
  logic [31:0]           mergeCnt_q, mergeCnt_d;

  logic acceptI;
  logic acceptD;
  logic issue;
  logic inResp;
  logic rspI;
  logic rspD;

  // State and hold registers; lastD_q=0 means the ITLB was served last, so
  // the DTLB wins the first contested grant after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pendI_q    <= 1'b0;
      pendD_q    <= 1'b0;
      vpnI_q     <= '0;
      vpnD_q     <= '0;
      base_q     <= '0;
      merge_q    <= 1'b0;
      ownerD_q   <= 1'b0;
      lastD_q    <= 1'b0;
      rspPte_q   <= '0;
      rspErr_q   <= 1'b0;
      walkCnt_q  <= '0;
      mergeCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pendI_q    <= pendI_d;
      pendD_q    <= pendD_d;
      vpnI_q     <= vpnI_d;
      vpnD_q     <= vpnD_d;
      base_q     <= base_d;
      merge_q    <= merge_d;
      ownerD_q   <= ownerD_d;
      lastD_q    <= lastD_d;
      rspPte_q   <= rspPte_d;
      rspErr_q   <= rspErr_d;
      walkCnt_q  <= walkCnt_d;
      mergeCnt_q <= mergeCnt_d;
    end
  end

  assign acceptI = (state_q == IDLE) && !flush_i && itlb_req_valid_i;
  assign acceptD = (state_q == IDLE) && !flush_i && dtlb_req_valid_i;

  // Next-state logic: accept, pick an owner on every ISSUE entry, walk,
  // capture the answer, then serve it; flush squashes everything except the
  // counters and the round-robin history.
  always_comb begin
    state_d    = state_q;
    pendI_d    = pendI_q;
    pendD_d    = pendD_q;
    vpnI_d     = vpnI_q;
    vpnD_d     = vpnD_q;
    base_d     = base_q;
    merge_d    = merge_q;
    ownerD_d   = ownerD_q;
    lastD_d    = lastD_q;
    rspPte_d   = rspPte_q;
    rspErr_d   = rspErr_q;
    walkCnt_d  = walkCnt_q;
    mergeCnt_d = mergeCnt_q;

    unique case (state_q)
      IDLE: begin
        base_d = satp_ppn_i;
        if (acceptI) begin
          pendI_d = 1'b1;
          vpnI_d  = itlb_req_vpn_i;
        end
        if (acceptD) begin
          pendD_d = 1'b1;
          vpnD_d  = dtlb_req_vpn_i;
        end
        if (acceptI || acceptD) begin
          state_d = ISSUE;
          if (acceptI && acceptD) begin
            ownerD_d = !lastD_q;
            if (itlb_req_vpn_i == dtlb_req_vpn_i) begin
              merge_d    = 1'b1;
              mergeCnt_d = mergeCnt_q + 32'd1;
            end
          end else begin
            ownerD_d = acceptD;
          end
          lastD_d = ownerD_d;
        end
      end
      ISSUE: begin
        if (ptw_req_ready_i) begin
          walkCnt_d = walkCnt_q + 32'd1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (ptw_rsp_valid_i) begin
          rspPte_d = ptw_rsp_error_i ? '0 : ptw_rsp_pte_i;
          rspErr_d = ptw_rsp_error_i;
          state_d  = RESP;
        end
      end
      RESP: begin
        merge_d = 1'b0;
        if (merge_q) begin
          pendI_d = 1'b0;
          pendD_d = 1'b0;
          state_d = IDLE;
        end else if (ownerD_q) begin
          pendD_d = 1'b0;
          if (pendI_q) begin
            ownerD_d = 1'b0;
            lastD_d  = 1'b0;
            state_d  = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          pendI_d = 1'b0;
          if (pendD_q) begin
            ownerD_d = 1'b1;
            lastD_d  = 1'b1;
            state_d  = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d   = IDLE;
      pendI_d   = 1'b0;
      pendD_d   = 1'b0;
      merge_d   = 1'b0;
      ownerD_d  = 1'b0;
      lastD_d   = lastD_q;
      rspPte_d  = rspPte_q;
      rspErr_d  = rspErr_q;
      walkCnt_d = walkCnt_q;
    end
  end

  assign issue  = (state_q == ISSUE);
  assign inResp = (state_q == RESP) && !flush_i;
  assign rspI   = inResp && (merge_q || !ownerD_q);
  assign rspD   = inResp && (merge_q || ownerD_q);

  assign itlb_req_ready_o = (state_q == IDLE) && !flush_i;
  assign dtlb_req_ready_o = (state_q == IDLE) && !flush_i;

  assign ptw_req_valid_o = issue && !flush_i;
  assign ptw_req_addr_o  = issue ? ADDR_WIDTH'({base_q, 12'h000}) : '0;
  assign ptw_req_vpn_o   = issue ? (ownerD_q ? vpnD_q : vpnI_q) : '0;

  assign itlb_rsp_valid_o = rspI;
  assign itlb_rsp_pte_o   = rspI ? rspPte_q : '0;
  assign itlb_rsp_error_o = rspI && rspErr_q;
  assign dtlb_rsp_valid_o = rspD;
  assign dtlb_rsp_pte_o   = rspD ? rspPte_q : '0;
  assign dtlb_rsp_error_o = rspD && rspErr_q;

  assign busy_o      = (state_q != IDLE);
  assign walk_cnt_o  = walkCnt_q;
  assign merge_cnt_o = mergeCnt_q;

endmodule

// File: tb/tb_ptw_arbiter.sv
// tb_ptw_arbiter: drives ITLB/DTLB misses and plays the walker, predicting
// walk order, walk contents, responses and counters from a transaction-level
// model of the arbitration rules.
module tb_ptw_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [21:0] satpPpn;
  logic        itlbReqValid, itlbReqReady;
  logic [19:0] itlbReqVpn;
  logic        itlbRspValid, itlbRspError;
  logic [63:0] itlbRspPte;
  logic        dtlbReqValid, dtlbReqReady;
  logic [19:0] dtlbReqVpn;
  logic        dtlbRspValid, dtlbRspError;
  logic [63:0] dtlbRspPte;
  logic        ptwReqValid, ptwReqReady;
  logic [31:0] ptwReqAddr;
  logic [19:0] ptwReqVpn;
  logic        ptwRspValid, ptwRspError;
  logic [63:0] ptwRspPte;
  logic        busy;
  logic [31:0] walkCnt, mergeCnt;

  int checks = 0;
  int errors = 0;

  // model: who was served most recently, and the expected counter values
  bit          lastWasD;
  logic [31:0] expWalk;
  logic [31:0] expMerge;

  always #5 clk = ~clk;

  ptw_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .satp_ppn_i(satpPpn),
    .itlb_req_valid_i(itlbReqValid), .itlb_req_ready_o(itlbReqReady),
    .itlb_req_vpn_i(itlbReqVpn), .itlb_rsp_valid_o(itlbRspValid),
    .itlb_rsp_pte_o(itlbRspPte), .itlb_rsp_error_o(itlbRspError),
    .dtlb_req_valid_i(dtlbReqValid), .dtlb_req_ready_o(dtlbReqReady),
    .dtlb_req_vpn_i(dtlbReqVpn), .dtlb_rsp_valid_o(dtlbRspValid),
    .dtlb_rsp_pte_o(dtlbRspPte), .dtlb_rsp_error_o(dtlbRspError),
    .ptw_req_valid_o(ptwReqValid), .ptw_req_ready_i(ptwReqReady),
    .ptw_req_addr_o(ptwReqAddr), .ptw_req_vpn_o(ptwReqVpn),
    .ptw_rsp_valid_i(ptwRspValid), .ptw_rsp_pte_i(ptwRspPte),
    .ptw_rsp_error_i(ptwRspError), .busy_o(busy),
    .walk_cnt_o(walkCnt), .merge_cnt_o(mergeCnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rootAddr(input logic [21:0] ppn);
    logic [63:0] full;
    full = 64'(ppn) * 64'd4096;
    return full[31:0];
  endfunction

  task automatic checkIdle();
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_readyI", itlbReqReady, 1);
    checkOutput("idle_readyD", dtlbReqReady, 1);
    checkOutput("idle_rspI", itlbRspValid, 0);
    checkOutput("idle_rspD", dtlbRspValid, 0);
    checkOutput("idle_ptwValid", ptwReqValid, 0);
    checkOutput("walk_cnt", walkCnt, expWalk);
    checkOutput("merge_cnt", mergeCnt, expMerge);
  endtask

  task automatic doReset();
    rst = 1'b1; flush = 1'b0; satpPpn = '0;
    itlbReqValid = 1'b0; itlbReqVpn = '0;
    dtlbReqValid = 1'b0; dtlbReqVpn = '0;
    ptwReqReady = 1'b0; ptwRspValid = 1'b0; ptwRspPte = '0; ptwRspError = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lastWasD = 1'b0; expWalk = '0; expMerge = '0;
    #1;
    checkIdle();
    checkOutput("reset_addr", ptwReqAddr, 0);
    checkOutput("reset_pteI", itlbRspPte, 0);
    checkOutput("reset_pteD", dtlbRspPte, 0);
  endtask

  // One miss episode from IDLE back to IDLE; starts and ends just after a negedge.
  task automatic applyStimulus(input bit reqI, input bit reqD, input logic [19:0] vpnI,
                               input logic [19:0] vpnD, input logic [21:0] ppn,
                               input bit dirMode, input logic [63:0] dirPte,
                               input bit dirErr, input int dirDelay);
    int nW;
    bit both;
    bit wD[2];
    logic [63:0] pte;
    bit err;
    int delay;
    int lat;
    bit expI, expD;
    itlbReqValid = reqI; itlbReqVpn = vpnI;
    dtlbReqValid = reqD; dtlbReqVpn = vpnD;
    satpPpn = ppn;
    #1;
    checkOutput("acc_readyI", itlbReqReady, 1);
    checkOutput("acc_readyD", dtlbReqReady, 1);
    @(negedge clk);
    itlbReqValid = 1'b0; dtlbReqValid = 1'b0;
    satpPpn = 22'($urandom);
    both = 1'b0;
    if (reqI && reqD && vpnI == vpnD) begin
      nW = 1; both = 1'b1; wD[0] = !lastWasD; lastWasD = wD[0]; expMerge++;
    end else if (reqI && reqD) begin
      nW = 2; wD[0] = !lastWasD; wD[1] = !wD[0]; lastWasD = wD[1];
    end else begin
      nW = 1; wD[0] = reqD; lastWasD = reqD;
    end
    for (int k = 0; k < nW; k++) begin
      delay = dirMode ? dirDelay : int'($urandom_range(0, 3));
      for (int d = 0; d <= delay; d++) begin
        #1;
        checkOutput("req_valid", ptwReqValid, 1);
        checkOutput("req_addr", ptwReqAddr, rootAddr(ppn));
        checkOutput("req_vpn", ptwReqVpn, wD[k] ? vpnD : vpnI);
        checkOutput("req_walkcnt", walkCnt, expWalk);
        checkOutput("req_readyI", itlbReqReady, 0);
        if (d == delay) ptwReqReady = 1'b1;
        @(negedge clk);
      end
      ptwReqReady = 1'b0;
      expWalk++;
      #1;
      checkOutput("wait_walkcnt", walkCnt, expWalk);
      checkOutput("wait_valid", ptwReqValid, 0);
      lat = int'($urandom_range(0, 2));
      for (int l = 0; l < lat; l++) begin
        @(negedge clk);
        #1;
        checkOutput("wait_rspI", itlbRspValid, 0);
        checkOutput("wait_rspD", dtlbRspValid, 0);
      end
      pte = dirMode ? (dirPte ^ 64'(k)) : {$urandom, $urandom};
      err = dirMode ? (dirErr && k == 0) : ($urandom_range(0, 3) == 0);
      ptwRspValid = 1'b1; ptwRspPte = pte; ptwRspError = err;
      @(negedge clk);
      ptwRspValid = 1'b0; ptwRspPte = {$urandom, $urandom}; ptwRspError = 1'b0;
      expI = both || !wD[k];
      expD = both || wD[k];
      #1;
      checkOutput("rsp_validI", itlbRspValid, expI);
      checkOutput("rsp_validD", dtlbRspValid, expD);
      if (expI) begin
        checkOutput("rsp_pteI", itlbRspPte, err ? 64'd0 : pte);
        checkOutput("rsp_errI", itlbRspError, err);
      end
      if (expD) begin
        checkOutput("rsp_pteD", dtlbRspPte, err ? 64'd0 : pte);
        checkOutput("rsp_errD", dtlbRspError, err);
      end
      checkOutput("rsp_ptwValid", ptwReqValid, 0);
      @(negedge clk);
    end
    #1;
    checkIdle();
  endtask

  // Flush while WAITing with both TLBs pending and a walker answer colliding.
  task automatic flushTest();
    itlbReqValid = 1'b1; itlbReqVpn = 20'h00111;
    dtlbReqValid = 1'b1; dtlbReqVpn = 20'h00222;
    satpPpn = 22'h00123;
    @(negedge clk);
    itlbReqValid = 1'b0; dtlbReqValid = 1'b0;
    lastWasD = !lastWasD;
    #1;
    checkOutput("fl_vpn", ptwReqVpn, lastWasD ? 20'h00222 : 20'h00111);
    ptwReqReady = 1'b1;
    @(negedge clk);
    ptwReqReady = 1'b0;
    expWalk++;
    flush = 1'b1; ptwRspValid = 1'b1; ptwRspPte = 64'hDEAD; ptwRspError = 1'b0;
    #1;
    checkOutput("fl_rspI", itlbRspValid, 0);
    checkOutput("fl_rspD", dtlbRspValid, 0);
    checkOutput("fl_readyI", itlbReqReady, 0);
    checkOutput("fl_readyD", dtlbReqReady, 0);
    checkOutput("fl_ptwValid", ptwReqValid, 0);
    @(negedge clk);
    flush = 1'b0; ptwRspValid = 1'b0;
    #1;
    checkIdle();
    @(negedge clk);
    #1;
    checkIdle();
    flush = 1'b1;
    #1;
    checkOutput("fl_idle_ready", itlbReqReady, 0);
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    logic [19:0] vi, vd;
    int pat;
    $display("[TB] start");
    doReset();
    applyStimulus(1'b0, 1'b1, 20'h0, 20'h12345, 22'h00080, 1'b1, 64'h200000CF, 1'b0, 0);
    doReset();
    applyStimulus(1'b1, 1'b1, 20'h00001, 20'h00002, 22'h00040, 1'b1, 64'h1000, 1'b0, 0);
    doReset();
    applyStimulus(1'b1, 1'b1, 20'h0ABCD, 20'h0ABCD, 22'h3FFFFF, 1'b1, 64'h55, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 20'h00010, 20'h00020, 22'h00100, 1'b1, 64'hFFFF, 1'b1, 0);
    flushTest();
    applyStimulus(1'b1, 1'b0, 20'h00333, 20'h0, 22'h00200, 1'b1, 64'h77, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 20'h0, 20'h00444, 22'h00300, 1'b1, 64'h88, 1'b0, 5);
    for (int n = 0; n < 40; n++) begin
      pat = int'($urandom_range(1, 3));
      vi = 20'($urandom);
      vd = ($urandom_range(0, 2) == 0) ? vi : 20'($urandom);
      applyStimulus(pat[0], pat[1], vi, vd, 22'($urandom), 1'b0, 64'd0, 1'b0, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
